// File: rtl/ps2_kbd_ctrl_if.sv
// rtl/ps2_kbd_ctrl_if.sv - command/response link between ps2_kbd_ctrl and the ps2_host byte engine
interface ps2_kbd_ctrl_if;
  logic [7:0] host_tx_data;
  logic       host_send_req;
  logic       host_busy;
  logic [7:0] host_rx_data;
  logic       host_ready;
  logic       host_error;

  modport master (
    output host_tx_data, host_send_req,
    input  host_busy, host_rx_data, host_ready, host_error
  );

  modport slave (
    input  host_tx_data, host_send_req,
    output host_busy, host_rx_data, host_ready, host_error
  );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// rtl/ps2_kbd_ctrl.sv - PS/2 keyboard reset/BAT sequencer with scancode FIFO; LED update built with PS2_KBD_LED_EN
module ps2_kbd_ctrl #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int BAT_CYCLES     = 50_000_000,
  parameter int MAX_RETRY      = 3,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  ps2_kbd_ctrl_if.master host,
  input  logic [2:0] led_val,
  input  logic       led_req,
  output logic       led_busy,
  output logic       kbd_ok,
  output logic       kbd_fail,
  output logic [7:0] scan_data,
  output logic       scan_valid,
  input  logic       scan_pop,
  output logic       fifo_ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

`ifdef PS2_KBD_LED_EN
  localparam logic [7:0] CMD_LED = 8'hED;
  typedef enum logic [3:0] {
    RST_SEND, RST_ACK, BAT_WAIT, IDLE, CMD_SEND, CMD_ACK, ARG_SEND, ARG_ACK, FAIL
  } state_t;
  logic       led_pend;
  logic [2:0] led_cap;
  assign led_busy = led_pend;
`else
  typedef enum logic [3:0] {RST_SEND, RST_ACK, BAT_WAIT, IDLE, FAIL} state_t;
  logic led_unused;
  assign led_unused = ^{led_req, led_val};
  assign led_busy   = 1'b0;
`endif

  state_t        state, ack_next, ack_resend;
  logic [31:0]   tmr;
  logic [RW-1:0] retry;
  logic          is_ack, ack_ok, ack_retry, tmo;
  logic          push, push_ok, pop_ok, full;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;

  always_comb begin
    is_ack     = 1'b0;
    ack_next   = IDLE;
    ack_resend = RST_SEND;
    case (state)
      RST_ACK: begin is_ack = 1'b1; ack_next = BAT_WAIT; ack_resend = RST_SEND; end
`ifdef PS2_KBD_LED_EN
      CMD_ACK: begin is_ack = 1'b1; ack_next = ARG_SEND; ack_resend = CMD_SEND; end
      ARG_ACK: begin is_ack = 1'b1; ack_next = IDLE;     ack_resend = ARG_SEND; end
`endif
      default: ;
    endcase
  end

  // Timeout counts only idle-bus cycles, so it measures time since the frame left the wire.
  assign tmo       = !host.host_busy && (tmr == 32'(TIMEOUT_CYCLES - 1));
  assign ack_ok    = is_ack && host.host_ready && !host.host_error && (host.host_rx_data == RSP_ACK);
  assign ack_retry = is_ack && !ack_ok &&
                     ((host.host_ready && (host.host_error || host.host_rx_data == RSP_RESEND)) || tmo);

  assign push = host.host_ready && !host.host_error &&
                (state == IDLE || state == FAIL ||
                 (is_ack && host.host_rx_data != RSP_ACK && host.host_rx_data != RSP_RESEND));
  assign full       = (count == DEPTH_CNT);
  assign pop_ok     = scan_pop && (count != '0);
  assign push_ok    = push && (!full || pop_ok);
  assign scan_valid = (count != '0);
  assign scan_data  = scan_valid ? mem[rptr] : 8'h00;

  always_ff @(posedge sys_clk) begin
    if (push_ok) mem[wptr] <= host.host_rx_data;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      fifo_ovf <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      if (push && !push_ok) fifo_ovf <= 1'b1;
      count <= count + (AW + 1)'(push_ok) - (AW + 1)'(pop_ok);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state              <= RST_SEND;
      tmr                <= '0;
      retry              <= '0;
      host.host_tx_data  <= 8'h00;
      host.host_send_req <= 1'b0;
      kbd_ok             <= 1'b0;
      kbd_fail           <= 1'b0;
`ifdef PS2_KBD_LED_EN
      led_pend           <= 1'b0;
      led_cap            <= 3'b000;
`endif
    end else begin
      host.host_send_req <= 1'b0;
      if (is_ack) begin
        tmr <= host.host_busy ? 32'd0 : tmr + 32'd1;
        if (ack_ok) begin
          retry <= '0;
          state <= ack_next;
`ifdef PS2_KBD_LED_EN
          if (ack_next == IDLE) led_pend <= 1'b0;
`endif
        end else if (ack_retry) begin
          if (retry == RW'(MAX_RETRY)) begin
            state    <= FAIL;
            kbd_ok   <= 1'b0;
            kbd_fail <= 1'b1;
          end else begin
            retry <= retry + RW'(1);
            state <= ack_resend;
          end
        end
      end
      case (state)
        RST_SEND: if (!host.host_busy) begin
          host.host_tx_data  <= CMD_RESET;
          host.host_send_req <= 1'b1;
          tmr                <= '0;
          state              <= RST_ACK;
        end
        BAT_WAIT: begin
          tmr <= tmr + 32'd1;
          if (host.host_ready && (host.host_error || host.host_rx_data == RSP_BAT_FAIL)) begin
            state    <= FAIL;
            kbd_fail <= 1'b1;
          end else if (host.host_ready && host.host_rx_data == RSP_BAT_OK) begin
            state  <= IDLE;
            kbd_ok <= 1'b1;
          end else if (tmr == 32'(BAT_CYCLES - 1)) begin
            state    <= FAIL;
            kbd_fail <= 1'b1;
          end
        end
`ifdef PS2_KBD_LED_EN
        IDLE: if (led_pend) state <= CMD_SEND;
        CMD_SEND: if (!host.host_busy) begin
          host.host_tx_data  <= CMD_LED;
          host.host_send_req <= 1'b1;
          tmr                <= '0;
          state              <= CMD_ACK;
        end
        ARG_SEND: if (!host.host_busy) begin
          host.host_tx_data  <= {5'b00000, led_cap};
          host.host_send_req <= 1'b1;
          tmr                <= '0;
          state              <= ARG_ACK;
        end
`endif
        default: ;
      endcase
`ifdef PS2_KBD_LED_EN
      // A new request always wins over the end-of-sequence clear on the same edge.
      if (led_req) begin
        led_pend <= 1'b1;
        led_cap  <= led_val;
      end
`endif
    end
  end
endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb/tb_ps2_kbd_ctrl.sv - self-checking bench for ps2_kbd_ctrl with a scripted PS/2 device model
module tb_ps2_kbd_ctrl;
  localparam int TMO = 100, BAT = 500, RETRY = 3, DEPTH = 16;

  logic       clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [2:0] led_val = 3'b000;
  logic       led_req = 1'b0;
  logic       scan_pop = 1'b0;
  logic       led_busy, kbd_ok, kbd_fail, scan_valid, fifo_ovf;
  logic [7:0] scan_data;
  int errors = 0, checks = 0, n_sends = 0;

  ps2_kbd_ctrl_if hif();

  ps2_kbd_ctrl #(.TIMEOUT_CYCLES(TMO), .BAT_CYCLES(BAT), .MAX_RETRY(RETRY), .FIFO_DEPTH(DEPTH)) dut (
    .sys_clk(clk), .sys_rst(sys_rst), .host(hif),
    .led_val(led_val), .led_req(led_req), .led_busy(led_busy),
    .kbd_ok(kbd_ok), .kbd_fail(kbd_fail),
    .scan_data(scan_data), .scan_valid(scan_valid), .scan_pop(scan_pop), .fifo_ovf(fifo_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (hif.host_send_req === 1'b1) n_sends++;

  typedef struct {
    int         n_nak;
    bit         nak_err;
    bit         bat_none;
    logic [7:0] bat;
    bit         bat_err;
    int         exp_sends;
    bit         exp_ok;
    bit         exp_fail;
  } init_vec_t;
  init_vec_t tv[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reply(input logic [7:0] b, input bit err);
    hif.host_rx_data = b;
    hif.host_error   = err;
    hif.host_ready   = 1'b1;
    @(negedge clk);
    hif.host_ready   = 1'b0;
    hif.host_error   = 1'b0;
  endtask

  // Waits for a request, then plays the host: busy for 4 cycles (or left high when hold is set).
  task automatic expect_send(input logic [7:0] exp, input string name, input bit hold, output int cyc);
    cyc = 0;
    while (hif.host_send_req !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_req"}, 32'(hif.host_send_req), 1);
    chk({name, "_byte"}, 32'(hif.host_tx_data), 32'(exp));
    hif.host_busy = 1'b1;
    if (!hold) begin
      repeat (4) @(negedge clk);
      chk({name, "_hold"}, 32'(hif.host_tx_data), 32'(exp));
      chk({name, "_pulse"}, 32'(hif.host_send_req), 0);
      hif.host_busy = 1'b0;
    end
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    @(negedge clk);
    chk("rst_send_req", 32'(hif.host_send_req), 0);
    chk("rst_tx_data", 32'(hif.host_tx_data), 0);
    chk("rst_led_busy", 32'(led_busy), 0);
    chk("rst_kbd_ok", 32'(kbd_ok), 0);
    chk("rst_kbd_fail", 32'(kbd_fail), 0);
    chk("rst_scan_valid", 32'(scan_valid), 0);
    chk("rst_scan_data", 32'(scan_data), 0);
    chk("rst_fifo_ovf", 32'(fifo_ovf), 0);
    sys_rst = 1'b0;
  endtask

  task automatic do_init();
    int c;
    do_reset();
    expect_send(8'hFF, "init", 1'b0, c);
    reply(8'hFA, 1'b0);
    repeat (2) @(negedge clk);
    reply(8'hAA, 1'b0);
    chk("init_kbd_ok", 32'(kbd_ok), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int cyc, base;
    logic [7:0] mq[$];
    logic [7:0] exq[$];
    bit m_ovf, r_push, r_err, r_pop;
    logic [7:0] r_byte;

    tv[0] = '{0, 1'b0, 1'b0, 8'hAA, 1'b0, 1, 1'b1, 1'b0};
    tv[1] = '{2, 1'b0, 1'b0, 8'hAA, 1'b0, 3, 1'b1, 1'b0};
    tv[2] = '{3, 1'b1, 1'b0, 8'hAA, 1'b0, 4, 1'b1, 1'b0};
    tv[3] = '{4, 1'b0, 1'b0, 8'hAA, 1'b0, 4, 1'b0, 1'b1};
    tv[4] = '{0, 1'b0, 1'b0, 8'hFC, 1'b0, 1, 1'b0, 1'b1};
    tv[5] = '{0, 1'b0, 1'b0, 8'hAA, 1'b1, 1, 1'b0, 1'b1};
    tv[6] = '{1, 1'b0, 1'b1, 8'h00, 1'b0, 2, 1'b0, 1'b1};

    hif.host_busy = 1'b0; hif.host_ready = 1'b0; hif.host_error = 1'b0; hif.host_rx_data = 8'h00;
    repeat (2) @(negedge clk);

    // Init sequences: NAK/error retries, BAT pass/fail/timeout.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      base = n_sends;
      for (int s = 0; s < tv[v].exp_sends; s++) begin
        expect_send(8'hFF, "init_ff", 1'b0, cyc);
        if (s < tv[v].n_nak) reply(tv[v].nak_err ? 8'h00 : 8'hFE, tv[v].nak_err);
        else reply(8'hFA, 1'b0);
      end
      if (tv[v].n_nak <= RETRY) begin
        if (tv[v].bat_none) repeat (BAT + 20) @(negedge clk);
        else begin
          repeat (3) @(negedge clk);
          reply(tv[v].bat, tv[v].bat_err);
        end
      end
      repeat (20) @(negedge clk);
      chk("init_sends", 32'(n_sends - base), 32'(tv[v].exp_sends));
      chk("init_ok", 32'(kbd_ok), 32'(tv[v].exp_ok));
      chk("init_fail", 32'(kbd_fail), 32'(tv[v].exp_fail));
      chk("init_fifo_empty", 32'(scan_valid), 0);
      if (tv[v].exp_fail) begin
        reply(8'h33, 1'b0);
        chk("fail_fifo_valid", 32'(scan_valid), 1);
        chk("fail_fifo_data", 32'(scan_data), 32'h33);
        chk("fail_stays", 32'(kbd_fail), 1);
      end
    end

    // Ack timeout on the reset byte: decided on the 100th idle cycle, request issued from RST_SEND one cycle later.
    do_reset();
    expect_send(8'hFF, "tmo_first", 1'b0, cyc);
    expect_send(8'hFF, "tmo_resend", 1'b0, cyc);
    chk("tmo_cycles", 32'(cyc), 32'(TMO + 1));
    reply(8'hFA, 1'b0);
    repeat (2) @(negedge clk);
    reply(8'hAA, 1'b0);
    chk("tmo_then_ok", 32'(kbd_ok), 1);

    // Overflow: 17 bytes into a 16-deep FIFO, then order check.
    do_init();
    chk("fifo_empty_before", 32'(scan_valid), 0);
    for (int i = 0; i < 17; i++) begin
      reply(8'h1C + 8'(i), 1'b0);
      if (i == 0) chk("fifo_valid_next", 32'(scan_valid), 1);
    end
    chk("fifo_ovf_set", 32'(fifo_ovf), 1);
    for (int i = 0; i < 16; i++) begin
      chk("fifo_order", 32'(scan_data), 32'(8'h1C + 8'(i)));
      scan_pop = 1'b1;
      @(negedge clk);
    end
    scan_pop = 1'b0;
    chk("fifo_drained", 32'(scan_valid), 0);
    scan_pop = 1'b1;
    reply(8'h77, 1'b0);
    scan_pop = 1'b0;
    chk("pop_empty_valid", 32'(scan_valid), 1);
    chk("pop_empty_data", 32'(scan_data), 32'h77);
    scan_pop = 1'b1;
    @(negedge clk);
    scan_pop = 1'b0;
    chk("pop_empty_drain", 32'(scan_valid), 0);

    // Push and pop together on a full FIFO.
    do_init();
    exq.delete();
    for (int i = 0; i < 16; i++) begin
      reply(8'h40 + 8'(i), 1'b0);
      exq.push_back(8'h40 + 8'(i));
    end
    chk("full_no_ovf", 32'(fifo_ovf), 0);
    scan_pop = 1'b1;
    reply(8'h99, 1'b0);
    scan_pop = 1'b0;
    void'(exq.pop_front());
    exq.push_back(8'h99);
    chk("full_pushpop_ovf", 32'(fifo_ovf), 0);
    for (int i = 0; i < 16; i++) begin
      chk("full_pushpop_order", 32'(scan_data), 32'(exq[i]));
      scan_pop = 1'b1;
      @(negedge clk);
    end
    scan_pop = 1'b0;
    chk("full_pushpop_empty", 32'(scan_valid), 0);

    // Randomized scancode traffic against a queue model; phase 1 pops fast, phase 2 slow.
    do_init();
    mq.delete();
    m_ovf = 1'b0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 200; i++) begin
        r_push = ($urandom_range(0, 99) < 60);
        r_err  = ($urandom_range(0, 9) == 0);
        r_byte = 8'($urandom);
        r_pop  = ($urandom_range(0, 99) < (ph == 0 ? 70 : 30));
        hif.host_ready = r_push; hif.host_rx_data = r_byte; hif.host_error = r_err; scan_pop = r_pop;
        if (r_pop && mq.size() > 0) void'(mq.pop_front());
        if (r_push && !r_err) begin
          if (mq.size() < DEPTH) mq.push_back(r_byte);
          else m_ovf = 1'b1;
        end
        @(negedge clk);
        chk("rnd_valid", 32'(scan_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) chk("rnd_data", 32'(scan_data), 32'(mq[0]));
        else chk("rnd_data_empty", 32'(scan_data), 0);
        chk("rnd_ovf", 32'(fifo_ovf), 32'(m_ovf));
      end
    end
    hif.host_ready = 1'b0; hif.host_error = 1'b0; scan_pop = 1'b0;
    chk("rnd_still_ok", 32'(kbd_ok), 1);
    chk("rnd_no_fail", 32'(kbd_fail), 0);

`ifdef PS2_KBD_LED_EN
    // Second request while pending overwrites the value and does not queue another sequence.
    do_init();
    hif.host_busy = 1'b1;
    led_val = 3'b101; led_req = 1'b1;
    @(negedge clk);
    led_req = 1'b0;
    chk("led_busy_set", 32'(led_busy), 1);
    led_val = 3'b011; led_req = 1'b1;
    @(negedge clk);
    led_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("led_wait_bus", 32'(hif.host_send_req), 0);
    hif.host_busy = 1'b0;
    expect_send(8'hED, "led_cmd", 1'b0, cyc);
    reply(8'hFA, 1'b0);
    expect_send(8'h03, "led_arg_ovw", 1'b0, cyc);
    chk("led_busy_mid", 32'(led_busy), 1);
    reply(8'hFA, 1'b0);
    chk("led_busy_clr", 32'(led_busy), 0);
    base = n_sends;
    repeat (50) @(negedge clk);
    chk("led_single_seq", 32'(n_sends - base), 0);

    led_val = 3'b101; led_req = 1'b1;
    @(negedge clk);
    led_req = 1'b0;
    expect_send(8'hED, "led_cmd2", 1'b0, cyc);
    expect_send(8'hED, "led_cmd_resend", 1'b0, cyc);
    chk("led_tmo_cycles", 32'(cyc), 32'(TMO + 1));
    reply(8'hFA, 1'b0);
    expect_send(8'h05, "led_arg", 1'b0, cyc);
    reply(8'hFA, 1'b0);
    chk("led_busy_done", 32'(led_busy), 0);
    chk("led_kbd_ok", 32'(kbd_ok), 1);
`else
    do_init();
    led_val = 3'b111; led_req = 1'b1;
    @(negedge clk);
    led_req = 1'b0;
    chk("noled_busy", 32'(led_busy), 0);
    base = n_sends;
    repeat (50) @(negedge clk);
    chk("noled_no_send", 32'(n_sends - base), 0);
    chk("noled_ok", 32'(kbd_ok), 1);
`endif

    // Reset mid-frame with a byte buffered and the bus still busy.
    do_reset();
    expect_send(8'hFF, "mid_first", 1'b1, cyc);
    reply(8'h5A, 1'b0);
    chk("ack_push_valid", 32'(scan_valid), 1);
    chk("ack_push_data", 32'(scan_data), 32'h5A);
    do_reset();
    base = n_sends;
    repeat (5) @(negedge clk);
    chk("mid_no_send_busy", 32'(n_sends - base), 0);
    hif.host_busy = 1'b0;
    expect_send(8'hFF, "mid_restart", 1'b0, cyc);
    reply(8'hFA, 1'b0);
    repeat (2) @(negedge clk);
    reply(8'hAA, 1'b0);
    chk("mid_ok", 32'(kbd_ok), 1);
    chk("mid_sends", 32'(n_sends - base), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ps2_kbd_ctrl.md
PS2_KBD_CTRL -- requirements
Module: ps2_kbd_ctrl

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 1_000_000, sys_clk cycles allowed for a device acknowledge (0xFA/0xFE) after host_busy falls.
REQ-002 SHALL provide parameter BAT_CYCLES, default 50_000_000, sys_clk cycles allowed for the BAT result after reset ACK.
REQ-003 SHALL provide parameter MAX_RETRY, default 3, resends per byte before failure.
REQ-004 SHALL provide parameter FIFO_DEPTH, default 16, power of two >= 2, scancode FIFO entries.
REQ-005 SHALL have ports, one per line:
  sys_clk  in  1  single clock, all logic on rising edge
  sys_rst  in  1  synchronous, active-high reset
  host_tx_data  out  8  byte to ps2_host tx_data
  host_send_req  out  1  one-cycle pulse to ps2_host send_req
  host_busy  in  1  ps2_host busy
  host_rx_data  in  8  ps2_host rx_data
  host_ready  in  1  ps2_host ready, one-cycle strobe
  host_error  in  1  ps2_host error (parity/frame)
  led_val  in  3  {caps,num,scroll}
  led_req  in  1  pulse, request LED update
  led_busy  out  1  LED sequence pending/active
  kbd_ok  out  1  initialization passed, controller idle-capable
  kbd_fail  out  1  sticky failure
  scan_data  out  8  FIFO head
  scan_valid  out  1  FIFO non-empty
  scan_pop  in  1  consume head when scan_valid
  fifo_ovf  out  1  sticky overflow flag

Function
REQ-006 SHALL implement states RST_SEND, RST_ACK, BAT_WAIT, IDLE, CMD_SEND, CMD_ACK, ARG_SEND, ARG_ACK, FAIL.
REQ-007 After reset SHALL enter RST_SEND and issue 0xFF: host_tx_data set and host_send_req pulsed for exactly one cycle, only in a cycle where host_busy=0; host_tx_data held until host_busy returns to 0.
REQ-008 *_ACK states: timeout counter cleared on entry, starts counting once host_busy=0; host_ready with 0xFA advances (RST_ACK->BAT_WAIT, CMD_ACK->ARG_SEND, ARG_ACK->IDLE).
REQ-009 In *_ACK, 0xFE, host_error, or counter reaching TIMEOUT_CYCLES SHALL resend the same byte (return to matching *_SEND) and increment retry count; retry count reaching MAX_RETRY instead SHALL go to FAIL.
REQ-010 Retry count SHALL clear on every accepted 0xFA.
REQ-011 BAT_WAIT: 0xAA -> IDLE, kbd_ok=1; 0xFC, host_error or BAT_CYCLES expiry -> FAIL.
REQ-012 led_req SHALL be latched (led_busy=1 next cycle) with led_val captured at the same edge; latched request SHALL start CMD_SEND from IDLE only; a led_req while led_busy=1 SHALL overwrite captured led_val and not queue a second sequence.
REQ-013 CMD_SEND SHALL send 0xED; ARG_SEND SHALL send {5'b0, captured led_val}; led_busy SHALL clear on the cycle IDLE is re-entered.
REQ-014 Any host_ready byte in IDLE, or in *_ACK other than 0xFA/0xFE, SHALL be pushed to the FIFO; scan_valid rises the cycle after host_ready.
REQ-015 host_ready with host_error=1 SHALL never push; in IDLE it SHALL be dropped silently.
REQ-016 FIFO full push without simultaneous pop SHALL be dropped and set fifo_ovf; push and pop in the same cycle when full SHALL both succeed without overflow; scan_pop while empty SHALL be ignored.
REQ-017 scan_data SHALL be valid whenever scan_valid=1 and change only after a pop or from empty to non-empty.
REQ-018 FAIL SHALL be absorbing until sys_rst: kbd_fail=1, kbd_ok=0, no host_send_req, FIFO still accepts bytes.
REQ-019 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.

Reset
REQ-020 sys_rst SHALL, at any state including mid-transmit, force RST_SEND, clear FIFO, counters, retry count and led latch, and drive host_send_req=0, host_tx_data=0, led_busy=0, kbd_ok=0, kbd_fail=0, scan_valid=0, scan_data=0, fifo_ovf=0.

Configuration
REQ-021 With macro PS2_KBD_LED_EN defined, LED update per REQ-012/013 SHALL be built; without it, CMD_SEND/CMD_ACK/ARG_SEND/ARG_ACK SHALL be absent, led_req and led_val ignored, led_busy tied 0.

Verification
REQ-022 Reset; device model returns 0xFA then 0xAA -> kbd_ok=1 after BAT, exactly one host_send_req with 0xFF.
REQ-023 Device answers 0xFE twice then 0xFA to 0xFF, MAX_RETRY=3 -> three 0xFF pulses, init succeeds; four 0xFE -> kbd_fail=1 after 4th 0xFE.
REQ-024 PS2_KBD_LED_EN set, led_val=3'b101, led_req -> bytes 0xED then 0x05 sent, led_busy low after second 0xFA.
REQ-025 In IDLE device sends 17 bytes 0x1C.., no pops, FIFO_DEPTH=16 -> 16 bytes retained in order, fifo_ovf=1; pop-on-full with push -> no ovf.
REQ-026 No ACK after 0xED, TIMEOUT_CYCLES=100 -> resend at cycle 100 after host_busy falls; sys_rst mid-frame -> all outputs at reset values next cycle, new 0xFF sequence.
